ballot_box: RTL and testbench

- Collects individual ballots over a valid/ready handshake and assembles them into the `np[31:0]`, `vip[7:0]` and `vvip` yes-vectors.
- These vectors drive the downstream combinational weighted-tally stage, `vote`.
- Rejects duplicate and malformed ballots.
- Sequences a voting session (open → close → result) and latches the tally stage's `res` into a stable result register when the session closes.

---
 rtl/vote_pkg.sv | 22 ++
 rtl/ballot_box_if.sv | 13 +
 rtl/ballot_box.sv | 122 ++++++++++++
 tb/tb_ballot_box.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared class codes, FSM encoding and voter counts for the ballot/vote pair
package vote_pkg;

  localparam int NP_N    = 32;
  localparam int VIP_N   = 8;
  localparam int TOTAL_N = 41;

  typedef enum logic [1:0] {
    CLS_NP   = 2'd0,
    CLS_VIP  = 2'd1,
    CLS_VVIP = 2'd2,
    CLS_RSV  = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPEN    = 2'd1,
    S_CLOSING = 2'd2,
    S_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/ballot_box_if.sv
// rtl/ballot_box_if.sv - ballot handshake bundle (voter class/id/yes with valid/ready)
interface ballot_box_if;

  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_class;
  logic [4:0] in_id;
  logic       in_yes;

  modport master (output in_valid, output in_class, output in_id, output in_yes, input in_ready);
  modport slave  (input in_valid, input in_class, input in_id, input in_yes, output in_ready);

endinterface

// File: rtl/ballot_box.sv
// rtl/ballot_box.sv - collects ballots into yes-vectors for the vote stage and latches the session result
module ballot_box
  import vote_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             close,
  ballot_box_if.slave      bal,
  output logic [NP_N-1:0]  np_o,
  output logic [VIP_N-1:0] vip_o,
  output logic             vvip_o,
  input  logic             res_i,
  output logic             result,
  output logic             done,
  output logic             err_dup,
  output logic             err_bad,
  output logic [5:0]       cast_cnt
);

  state_e           state, state_nxt;
  logic [NP_N-1:0]  cast_np;
  logic [VIP_N-1:0] cast_vip;
  logic             cast_vvip;

  cls_e cls;
  logic take, clear, is_bad, already, is_valid, last_vote;

  assign bal.in_ready = (state == S_OPEN);
  assign cls          = cls_e'(bal.in_class);
  assign take         = bal.in_valid && (state == S_OPEN);
  // start is honoured everywhere except CLOSING, and every honoured start re-enters OPEN
  assign clear        = start && (state != S_CLOSING);

  assign is_bad = (cls == CLS_RSV) ||
                  ((cls == CLS_VIP) && (bal.in_id > 5'd7)) ||
                  ((cls == CLS_VVIP) && (bal.in_id != 5'd0));

  always_comb begin
    already = 1'b0;
    case (cls)
      CLS_NP:   already = cast_np[bal.in_id];
      CLS_VIP:  already = cast_vip[bal.in_id[2:0]];
      CLS_VVIP: already = cast_vvip;
      default:  already = 1'b0;
    endcase
  end

  assign is_valid  = take && !is_bad && !already;
  assign last_vote = is_valid && (cast_cnt == 6'(TOTAL_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_OPEN;
      S_OPEN: begin
        if (start)                   state_nxt = S_OPEN;
        else if (close || last_vote) state_nxt = S_CLOSING;
      end
      S_CLOSING: state_nxt = S_DONE;
      S_DONE:    if (start) state_nxt = S_OPEN;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      np_o      <= '0;
      vip_o     <= '0;
      vvip_o    <= 1'b0;
      cast_np   <= '0;
      cast_vip  <= '0;
      cast_vvip <= 1'b0;
      cast_cnt  <= '0;
      result    <= 1'b0;
      done      <= 1'b0;
      err_dup   <= 1'b0;
      err_bad   <= 1'b0;
    end else begin
      err_dup <= 1'b0;
      err_bad <= 1'b0;
      done    <= (state == S_CLOSING);
      if (clear) begin
        np_o      <= '0;
        vip_o     <= '0;
        vvip_o    <= 1'b0;
        cast_np   <= '0;
        cast_vip  <= '0;
        cast_vvip <= 1'b0;
        cast_cnt  <= '0;
        result    <= 1'b0;
      end else begin
        if (state == S_CLOSING) result <= res_i;
        if (take && is_bad)                err_bad <= 1'b1;
        else if (take && already)          err_dup <= 1'b1;
        if (is_valid) begin
          cast_cnt <= cast_cnt + 6'd1;
          case (cls)
            CLS_NP: begin
              cast_np[bal.in_id] <= 1'b1;
              np_o[bal.in_id]    <= bal.in_yes;
            end
            CLS_VIP: begin
              cast_vip[bal.in_id[2:0]] <= 1'b1;
              vip_o[bal.in_id[2:0]]    <= bal.in_yes;
            end
            default: begin
              cast_vvip <= 1'b1;
              vvip_o    <= bal.in_yes;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ballot_box.sv
// tb/tb_ballot_box.sv - scoreboard bench for ballot_box with a behavioural weighted-tally vote stage
module tb_ballot_box;
  import vote_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, close, res_i;
  logic [31:0] np_o;
  logic [7:0]  vip_o;
  logic        vvip_o, result, done, err_dup, err_bad;
  logic [5:0]  cast_cnt;

  ballot_box_if bal();

  ballot_box dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .close    (close),
    .bal      (bal),
    .np_o     (np_o),
    .vip_o    (vip_o),
    .vvip_o   (vvip_o),
    .res_i    (res_i),
    .result   (result),
    .done     (done),
    .err_dup  (err_dup),
    .err_bad  (err_bad),
    .cast_cnt (cast_cnt)
  );

  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_miss = 0;
  logic exp_q[$];
  logic sb_exp;

  logic [31:0] m_np, m_cnp;
  logic [7:0]  m_vip, m_cvip;
  logic        m_vvip, m_cvvip;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // normal = 1, VIP = 4, VVIP = 16; the motion carries at 32 or more
  function automatic logic tally_res(input logic [31:0] np, input logic [7:0] vip, input logic vv);
    int t;
    t = $countones(np) + 4 * $countones(vip) + (vv ? 16 : 0);
    return t >= 32;
  endfunction

  always_comb res_i = tally_res(np_o, vip_o, vvip_o);

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
      else begin
        sb_exp = exp_q.pop_front();
        check("result_sb", {31'd0, result}, {31'd0, sb_exp});
      end
    end
  end

  task automatic model_clear();
    m_np = '0; m_cnp = '0; m_vip = '0; m_cvip = '0; m_vvip = 1'b0; m_cvvip = 1'b0; m_cnt = 0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    model_clear();
  endtask

  task automatic ballot(input logic [1:0] c, input logic [4:0] id, input logic y);
    logic bad, dup;
    bad = (c == 2'd3) || ((c == 2'd1) && (id > 5'd7)) || ((c == 2'd2) && (id != 5'd0));
    dup = 1'b0;
    if (!bad) begin
      case (c)
        2'd0:    dup = m_cnp[id];
        2'd1:    dup = m_cvip[id[2:0]];
        default: dup = m_cvvip;
      endcase
    end
    @(negedge clk);
    bal.in_valid = 1'b1; bal.in_class = c; bal.in_id = id; bal.in_yes = y;
    check("in_ready_open", {31'd0, bal.in_ready}, 32'd1);
    @(posedge clk); #1;
    bal.in_valid = 1'b0;
    if (!bad && !dup) begin
      case (c)
        2'd0:    begin m_cnp[id] = 1'b1; m_np[id] = y; end
        2'd1:    begin m_cvip[id[2:0]] = 1'b1; m_vip[id[2:0]] = y; end
        default: begin m_cvvip = 1'b1; m_vvip = y; end
      endcase
      m_cnt++;
      if (m_cnt == TOTAL_N) exp_q.push_back(tally_res(m_np, m_vip, m_vvip));
    end
    check("err_bad", {31'd0, err_bad}, {31'd0, bad});
    check("err_dup", {31'd0, err_dup}, {31'd0, dup});
    check("cast_cnt", {26'd0, cast_cnt}, 32'(m_cnt));
  endtask

  task automatic do_close();
    @(negedge clk); close = 1'b1;
    exp_q.push_back(tally_res(m_np, m_vip, m_vvip));
    @(posedge clk); #1; close = 1'b0;
    check("done_early", {31'd0, done}, 32'd0);
    check("in_ready_closing", {31'd0, bal.in_ready}, 32'd0);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_vectors(input string tag);
    check({tag, "_np"}, np_o, m_np);
    check({tag, "_vip"}, {24'd0, vip_o}, {24'd0, m_vip});
    check({tag, "_vvip"}, {31'd0, vvip_o}, {31'd0, m_vvip});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, {31'd0, bal.in_ready}, 32'd0);
    check({tag, "_np"}, np_o, 32'd0);
    check({tag, "_vip"}, {24'd0, vip_o}, 32'd0);
    check({tag, "_vvip"}, {31'd0, vvip_o}, 32'd0);
    check({tag, "_result"}, {31'd0, result}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_errs"}, {30'd0, err_dup, err_bad}, 32'd0);
    check({tag, "_cnt"}, {26'd0, cast_cnt}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; close = 1'b0;
    bal.in_valid = 1'b0; bal.in_class = 2'd0; bal.in_id = 5'd0; bal.in_yes = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk); rst_n = 1'b1;

    // 32 normal yes -> tally 32 carries
    do_start();
    for (int i = 0; i < 32; i++) ballot(2'd0, 5'(i), 1'b1);
    check("all_np", np_o, 32'hFFFF_FFFF);
    check("cnt32", {26'd0, cast_cnt}, 32'd32);
    do_close();
    check("result_32", {31'd0, result}, 32'd1);

    // 7 VIP + 3 normal -> 31 fails
    do_start();
    check_vectors("restart_clear");
    for (int i = 0; i < 7; i++) ballot(2'd1, 5'(i), 1'b1);
    for (int i = 0; i < 3; i++) ballot(2'd0, 5'(i), 1'b1);
    do_close();
    check("result_31", {31'd0, result}, 32'd0);

    // VVIP alone is 16, plus 16 normal reaches 32
    do_start();
    ballot(2'd2, 5'd0, 1'b1);
    check_vectors("vvip_only");
    for (int i = 0; i < 16; i++) ballot(2'd0, 5'(i + 8), 1'b1);
    do_close();
    check("result_vvip", {31'd0, result}, 32'd1);

    // duplicate and malformed ballots
    do_start();
    ballot(2'd1, 5'd3, 1'b1);
    ballot(2'd1, 5'd3, 1'b0);
    check("dup_vip3", {24'd0, vip_o}, 32'h08);
    ballot(2'd3, 5'd0, 1'b1);
    ballot(2'd1, 5'd9, 1'b1);
    ballot(2'd2, 5'd1, 1'b1);
    check_vectors("after_bad");
    check("bad_ready", {31'd0, bal.in_ready}, 32'd1);
    check("bad_cnt", {26'd0, cast_cnt}, 32'd1);

    // full house triggers auto-close
    do_start();
    for (int i = 0; i < 32; i++) ballot(2'd0, 5'(i), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) ballot(2'd1, 5'(i), 1'($urandom_range(0, 1)));
    ballot(2'd2, 5'd0, 1'($urandom_range(0, 1)));
    check_vectors("full");
    @(negedge clk);
    bal.in_valid = 1'b1; bal.in_class = 2'd0; bal.in_id = 5'd0; bal.in_yes = 1'b1;
    check("ballot42_ready", {31'd0, bal.in_ready}, 32'd0);
    @(posedge clk); #1;
    bal.in_valid = 1'b0;
    check("auto_done", {31'd0, done}, 32'd1);
    check("cnt41", {26'd0, cast_cnt}, 32'd41);
    @(posedge clk); #1;
    check("auto_drained", 32'(exp_q.size()), 32'd0);
    check_vectors("done_hold");

    // start with close in OPEN restarts instead of closing
    do_start();
    ballot(2'd0, 5'd5, 1'b1);
    ballot(2'd1, 5'd2, 1'b1);
    @(negedge clk); start = 1'b1; close = 1'b1;
    @(posedge clk); #1; start = 1'b0; close = 1'b0;
    model_clear();
    check("sc_ready", {31'd0, bal.in_ready}, 32'd1);
    check("sc_cnt", {26'd0, cast_cnt}, 32'd0);
    check_vectors("sc_clear");
    @(posedge clk); #1;
    check("sc_no_done", {31'd0, done}, 32'd0);
    check("sc_still_open", {31'd0, bal.in_ready}, 32'd1);

    // asynchronous reset mid-session
    ballot(2'd0, 5'd1, 1'b1);
    ballot(2'd2, 5'd0, 1'b1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_rst", {31'd0, bal.in_ready}, 32'd0);

    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
